dynamic_pattern_detector: RTL and testbench



---
 rtl/pattern_det_pkg.sv | 14 +
 rtl/valid_shift_reg.sv | 35 +++
 rtl/dynamic_pattern_detector.sv | 55 +++++
 tb/tb_dynamic_pattern_detector.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pattern_det_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
package pattern_det_pkg;

    localparam int DEF_PAT_WIDTH = 5;
    localparam logic [DEF_PAT_WIDTH-1:0] DEF_PATTERN = 5'b11010;

    // Fill counter type for the default width; other widths size via fill_bits().
    typedef logic [$clog2(DEF_PAT_WIDTH+1)-1:0] fill_t;

    function automatic int fill_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/valid_shift_reg.sv
// Enable-qualified shift register holding the most recent valid bits,
// plus a fill counter that saturates at the register width.
module valid_shift_reg
    import pattern_det_pkg::*;
#(
    parameter int WIDTH  = DEF_PAT_WIDTH,
    parameter int FILL_W = fill_bits(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic              i_d,
    output logic [WIDTH-1:0]  o_hist,
    output logic [FILL_W-1:0] o_fill
);

    logic [WIDTH-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (i_en) begin
            r_hist <= {r_hist[WIDTH-2:0], i_d};
            if (r_fill != FILL_W'(WIDTH)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

    assign o_hist = r_hist;
    assign o_fill = r_fill;

endmodule

// File: rtl/dynamic_pattern_detector.sv
// Overlapping serial pattern detector: compares the incoming valid bit joined
// with the stored history against PATTERN and registers a one-cycle pulse.
module dynamic_pattern_detector
    import pattern_det_pkg::*;
#(
    parameter int                   PAT_WIDTH = DEF_PAT_WIDTH,
    parameter logic [PAT_WIDTH-1:0] PATTERN   = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    input  logic v_i,
    output logic pattern_detect
);

    localparam int FILL_W = fill_bits(PAT_WIDTH);

    logic [PAT_WIDTH-1:0] w_hist;
    logic [FILL_W-1:0]    w_fill;
    logic [PAT_WIDTH-1:0] w_window;
    logic                 w_filled;
    logic                 w_match;
    logic                 w_unused_oldest;
    logic                 r_detect;

    valid_shift_reg #(
        .WIDTH  (PAT_WIDTH),
        .FILL_W (FILL_W)
    ) u_hist (
        .clk    (clk),
        .rst    (rst),
        .i_en   (v_i),
        .i_d    (d_i),
        .o_hist (w_hist),
        .o_fill (w_fill)
    );

    // The oldest history bit falls out of the window as the new bit arrives.
    assign w_unused_oldest = w_hist[PAT_WIDTH-1];
    assign w_window        = {w_hist[PAT_WIDTH-2:0], d_i};
    // A window only counts once every position holds a bit received since reset.
    assign w_filled        = (w_fill >= FILL_W'(PAT_WIDTH - 1));
    assign w_match         = v_i && w_filled && (w_window == PATTERN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_detect <= 1'b0;
        end else begin
            r_detect <= w_match;
        end
    end

    assign pattern_detect = r_detect;

endmodule

// File: tb/tb_dynamic_pattern_detector.sv
// Self-checking bench: five detector variants share one stimulus stream and are
// checked every cycle against a queue-based model, plus directed pulse positions.
module tb_dynamic_pattern_detector;

    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic         d;
    logic         v;
    logic [N-1:0] det;

    dynamic_pattern_detector u_def (
        .clk(clk), .rst(rst), .d_i(d), .v_i(v), .pattern_detect(det[0]));
    dynamic_pattern_detector #(.PAT_WIDTH(5), .PATTERN(5'b10101)) u_alt (
        .clk(clk), .rst(rst), .d_i(d), .v_i(v), .pattern_detect(det[1]));
    dynamic_pattern_detector #(.PAT_WIDTH(2), .PATTERN(2'b11)) u_ones (
        .clk(clk), .rst(rst), .d_i(d), .v_i(v), .pattern_detect(det[2]));
    dynamic_pattern_detector #(.PAT_WIDTH(5), .PATTERN(5'b00000)) u_zero (
        .clk(clk), .rst(rst), .d_i(d), .v_i(v), .pattern_detect(det[3]));
    dynamic_pattern_detector #(.PAT_WIDTH(3), .PATTERN(3'b101)) u_three (
        .clk(clk), .rst(rst), .d_i(d), .v_i(v), .pattern_detect(det[4]));

    int          wid [N] = '{5, 5, 2, 5, 3};
    logic [31:0] pat [N] = '{32'b11010, 32'b10101, 32'b11, 32'b00000, 32'b101};

    int total = 0;
    int bad   = 0;

    // Reference: every valid bit since reset, newest at the back.
    bit           hist_q[$];
    logic [N-1:0] exp_r;

    longint unsigned mask [N];
    int              sent_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_match(input int i);
        int sz;
        sz = hist_q.size();
        if (sz < wid[i]) return 1'b0;
        for (int k = 0; k < wid[i]; k++) begin
            if (hist_q[sz-1-k] != pat[i][k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q.delete();
            exp_r = '0;
        end else begin
            if (v === 1'b1) begin
                hist_q.push_back(d);
                if (hist_q.size() > 40) void'(hist_q.pop_front());
            end
            for (int i = 0; i < N; i++) exp_r[i] = (v === 1'b1) && model_match(i);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            total++;
            if (det[i] !== exp_r[i]) begin
                bad++;
                $display("FAIL det[%0d] t=%0t got=%b want=%b", i, $time, det[i], exp_r[i]);
            end
            if (det[i] === 1'b1 && sent_cnt > 0 && sent_cnt <= 64)
                mask[i] |= (64'd1 << (sent_cnt - 1));
        end
    end

    task automatic chk(input string name, input longint unsigned got, input longint unsigned want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end else begin
            $display("check %s ok value=0x%0h", name, got);
        end
    endtask

    task automatic send(input logic vv, input logic dd);
        @(negedge clk);
        v = vv;
        d = dd;
        @(posedge clk);
        if (vv) sent_cnt++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) send(1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        for (int k = n - 1; k >= 0; k--) send(1'b1, bits[k]);
    endtask

    // Asynchronous assert mid-cycle, check immediate clear, release at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("rst_clears_outputs", 64'(det), 64'd0);
        sent_cnt = 0;
        for (int i = 0; i < N; i++) mask[i] = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        v   = 1'b0;
        d   = 1'b0;
        sent_cnt = 0;
        for (int i = 0; i < N; i++) mask[i] = 0;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'(det), 64'd0);
        rst = 1'b1;

        // Default pattern over a 20-bit stream: hits end at bits 8 and 16.
        send_bits(32'b01101101011011010101, 20);
        idle(3);
        chk("t1_default_stream", mask[0], (64'd1 << 8) | (64'd1 << 16));

        // 10101 overlapping on 1010101.
        do_reset();
        send_bits(32'b1010101, 7);
        idle(2);
        chk("t2_overlap_10101", mask[1], (64'd1 << 4) | (64'd1 << 6));

        // Pattern spanning a gap of invalid cycles.
        do_reset();
        send_bits(32'b110, 3);
        send(1'b0, 1'b1);
        send(1'b0, 1'bx);
        send(1'b0, 1'b0);
        chk("t3_no_pulse_in_gap", mask[0], 64'd0);
        send_bits(32'b10, 2);
        idle(2);
        chk("t3_gap_spanning", mask[0], 64'd1 << 4);

        // Reset mid-pattern discards the partial match.
        do_reset();
        send_bits(32'b1101, 4);
        do_reset();
        send(1'b1, 1'b0);
        idle(2);
        chk("t4_partial_discarded", mask[0], 64'd0);
        send_bits(32'b11010, 5);
        idle(2);
        chk("t4_full_after_reset", mask[0], 64'd1 << 5);

        // Shift-1 overlap: 11 on 1111 pulses three cycles in a row.
        do_reset();
        send_bits(32'b1111, 4);
        idle(2);
        chk("t5_back_to_back", mask[2], 64'he);

        // Reset while a pulse is high drops it.
        do_reset();
        send_bits(32'b11, 2);
        @(negedge clk);
        chk("t5_pulse_high", 64'(det[2]), 64'd1);
        do_reset();

        // All-zero pattern must not see the cleared history as valid zeros.
        send_bits(32'b0, 7);
        idle(2);
        chk("t6_zero_pattern", mask[3], (64'd1 << 4) | (64'd1 << 5) | (64'd1 << 6));

        // Randomised traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            send(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
